instr_mem_loader: RTL and testbench



---
 rtl/instr_mem_loader_pkg.sv | 20 ++
 rtl/instr_mem_loader_word_assembler.sv | 52 +++++
 rtl/instr_mem_loader.sv | 136 +++++++++++++
 tb/tb_instr_mem_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// CHECKSUM_EN adds the trailing-checksum CHECK state.
package instr_mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
`ifdef CHECKSUM_EN
        , ST_CHECK = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs accepted bytes little-endian into a word and pulses word_valid_o
// in the cycle after the last byte of the word has been accepted.
import instr_mem_loader_pkg::*;

module word_assembler (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              last_byte_o,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);
    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0]     cnt_q;
    logic [BYTE_W-1:0] lane_q [BYTES_PER_WORD];
    logic              word_valid_q;

    assign last_byte_o  = (cnt_q == CW'(BYTES_PER_WORD - 1));
    assign word_valid_o = word_valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= accept_i && last_byte_o;
            if (clear_i) begin
                cnt_q <= '0;
            end else if (accept_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (!reset) begin
                    lane_q[gi] <= '0;
                end else if (accept_i && cnt_q == CW'(gi)) begin
                    lane_q[gi] <= byte_i;
                end
            end
            assign word_o[gi*BYTE_W +: BYTE_W] = lane_q[gi];
        end
    endgenerate

endmodule

// File: rtl/instr_mem_loader.sv
// Fills the instruction BRAM from a byte stream and holds the CPU in reset
// until the image is loaded. Define CHECKSUM_EN to require a trailing XOR byte.
import instr_mem_loader_pkg::*;

module instr_mem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   num_q, num_d;
    logic                  load;
    logic                  accept, data_accept;
    logic                  last_byte, word_valid, last_word, start_ok;
    logic [31:0]           word;

    assign accept      = in_valid && in_ready;
    assign data_accept = accept && (state_q == ST_RECV);
    assign start_ok    = (num_words != '0) && (num_words <= MAX_WORDS);
    // The address doubles as the word counter: it equals the index of the word being written.
    assign last_word   = ({1'b0, addr_q} == (num_q - 1'b1));

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (load),
        .accept_i     (data_accept),
        .byte_i       (in_data),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

`ifdef CHECKSUM_EN
    logic [7:0] xor_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            xor_q <= '0;
        end else if (load) begin
            xor_q <= '0;
        end else if (data_accept) begin
            xor_q <= xor_q ^ in_data;
        end
    end

    assign in_ready = (state_q == ST_RECV) || (state_q == ST_CHECK);
    assign busy     = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
`else
    assign in_ready = (state_q == ST_RECV);
    assign busy     = (state_q == ST_RECV) || (state_q == ST_WRITE);
`endif

    assign bram_we    = word_valid;
    assign bram_addr  = addr_q;
    assign bram_wdata = word;
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERR);
    assign cpu_reset  = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        num_d   = num_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    if (start_ok) begin
                        state_d = ST_RECV;
                        addr_d  = '0;
                        num_d   = num_words;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_RECV: begin
                if (data_accept && last_byte) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The address is not advanced past the final word so it cannot wrap.
                if (last_word) begin
`ifdef CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_RECV;
                end
            end
`ifdef CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected BRAM writes are queued by
// the stimulus and checked by an independent write monitor.
module tb_instr_mem_loader;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready, bram_we, cpu_reset, busy, done, error;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata;

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  we_count = 0;
    int  last_we_cyc = 0;
    int  done_cyc = 0;
    int  cpu_busy_viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every bram_we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (busy && cpu_reset) cpu_busy_viol++;
        if (bram_we) begin
            we_count++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", bram_addr, bram_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(bram_addr), 32'(mon_e.addr));
                check("write_data", bram_wdata, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_words = n[AW:0];
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_byte: in_ready never 1 for byte 0x%02h, required 1", b);
        end
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_end();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done || error) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_end: done/error stayed 0 for 200 cycles, required 1");
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_bram_we"},    32'(bram_we),    32'd0);
        check({tag, "_bram_addr"},  32'(bram_addr),  32'd0);
        check({tag, "_bram_wdata"}, bram_wdata,      32'd0);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
    endtask

    int w0, v0;

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Two-word load with a stray start pulse during RECV.
        exp_q.push_back('{addr: 0, data: 32'h0000_0013});
        exp_q.push_back('{addr: 1, data: 32'hDEAD_BEEF});
        do_start(2);
        check("start_latency_in_ready", 32'(in_ready), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        send_byte(8'h13, 0);
        do_start(1);
        check("ignored_start_busy", 32'(busy), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_word(32'hDEAD_BEEF, 0);
`ifdef CHECKSUM_EN
        send_byte(8'h31, 0);
`endif
        wait_end();
        check("load1_done", 32'(done), 32'd1);
        check("load1_cpu_reset", 32'(cpu_reset), 32'd1);
        check("load1_error", 32'(error), 32'd0);
`ifndef CHECKSUM_EN
        check("load1_done_latency", 32'(done_cyc - last_we_cyc), 32'd1);
`endif

        // Reload from DONE with gaps between bytes.
        w0 = we_count;
        v0 = cpu_busy_viol;
        exp_q.push_back('{addr: 0, data: 32'h0000_0013});
        exp_q.push_back('{addr: 1, data: 32'hDEAD_BEEF});
        do_start(2);
        check("reload_cpu_reset_low", 32'(cpu_reset), 32'd0);
        send_word(32'h0000_0013, 3);
        send_word(32'hDEAD_BEEF, 3);
`ifdef CHECKSUM_EN
        send_byte(8'h31, 3);
`endif
        wait_end();
        check("gap_we_pulses", 32'(we_count - w0), 32'd2);
        check("reload_cpu_reset_while_busy", 32'(cpu_busy_viol - v0), 32'd0);
        check("gap_done", 32'(done), 32'd1);

        // Rejected word counts.
        w0 = we_count;
        do_start(0);
        wait_end();
        check("nw0_error", 32'(error), 32'd1);
        check("nw0_cpu_reset", 32'(cpu_reset), 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        do_start(1025);
        wait_end();
        check("nw1025_error", 32'(error), 32'd1);
        check("nw1025_cpu_reset", 32'(cpu_reset), 32'd0);
        check("nw_bad_no_writes", 32'(we_count - w0), 32'd0);

        // Full capacity is accepted.
        do_start(1024);
        check("nw1024_busy", 32'(busy), 32'd1);
        check("nw1024_error", 32'(error), 32'd0);

        // Reset after the 5th byte of a 3-word load.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        exp_q.push_back('{addr: 0, data: 32'h0403_0201});
        do_start(3);
        send_word(32'h0403_0201, 0);
        send_byte(8'h55, 0);
        reset = 1'b0;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b1;
        tick();

        // Reload from address 0 with one word.
        exp_q.push_back('{addr: 0, data: 32'h0403_0201});
        do_start(1);
        send_word(32'h0403_0201, 0);
`ifdef CHECKSUM_EN
        send_byte(8'h04, 0);
`endif
        wait_end();
        check("one_word_done", 32'(done), 32'd1);
        check("one_word_cpu_reset", 32'(cpu_reset), 32'd1);

`ifdef CHECKSUM_EN
        exp_q.push_back('{addr: 0, data: 32'h0403_0201});
        do_start(1);
        send_word(32'h0403_0201, 0);
        send_byte(8'h05, 0);
        wait_end();
        check("bad_csum_error", 32'(error), 32'd1);
        check("bad_csum_cpu_reset", 32'(cpu_reset), 32'd0);
        check("bad_csum_done", 32'(done), 32'd0);
`endif

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
